// File: rtl/systolic_n_if.sv
// Operand/result bundle for systolic_n: start/len command, operand beats in, one result element out per handshake.
// Master drives the request and operand side; slave (the array) drives ready, results and status.
interface systolic_n_if #(
    parameter int N    = 4,
    parameter int DW   = 16,
    parameter int ACCW = 40,
    parameter int LW   = 8
);
    localparam int RW = $clog2(N);

    logic              start;
    logic [LW-1:0]     len;
    logic [N*DW-1:0]   a_in;
    logic [N*DW-1:0]   b_in;
    logic              in_valid;
    logic              in_ready;
    logic [ACCW-1:0]   out_data;
    logic [RW-1:0]     out_row;
    logic [RW-1:0]     out_col;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        output start, len, a_in, b_in, in_valid, out_ready,
        input  in_ready, out_data, out_row, out_col, out_valid, out_last, busy, done
    );

    modport slave (
        input  start, len, a_in, b_in, in_valid, out_ready,
        output in_ready, out_data, out_row, out_col, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/systolic_n.sv
// Output-stationary NxN systolic matrix multiplier C = A x B; first result 1+K+2N-1 cycles after start, then one element per accepted beat.
// Input bubbles inject zeros into the skewed grid; output stalls freeze the result index and data.
module systolic_n #(
    parameter int N    = 4,
    parameter int DW   = 16,
    parameter int ACCW = 40,
    parameter int LW   = 8
) (
    input  logic         clk,
    input  logic         rst,
    systolic_n_if.slave  bus
);
    localparam int RW  = $clog2(N);
    localparam int DCW = $clog2(2*N);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LW-1:0]    r_len;
    logic [LW-1:0]    r_cnt;
    logic [DCW-1:0]   r_dcnt;
    logic [RW-1:0]    r_row;
    logic [RW-1:0]    r_col;
    logic             r_done;

    logic             w_clear;
    logic             w_adv;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_last_beat;
    logic             w_drain_end;
    logic             w_out_last;

    logic signed [DW-1:0]   w_a_lane [N];
    logic signed [DW-1:0]   w_b_lane [N];
    logic signed [DW-1:0]   w_a_sk   [N];
    logic signed [DW-1:0]   w_b_sk   [N];
    logic signed [DW-1:0]   w_pa     [N][N];
    logic signed [DW-1:0]   w_pb     [N][N];
    logic signed [ACCW-1:0] w_acc    [N][N];

    assign w_in_xfer   = (r_state == LOAD) && bus.in_valid;
    assign w_out_xfer  = (r_state == OUT) && bus.out_ready;
    assign w_last_beat = w_in_xfer && (r_cnt == r_len - LW'(1));
    assign w_drain_end = (r_dcnt == DCW'(2*N-2));
    assign w_out_last  = (r_state == OUT) && (r_row == RW'(N-1)) && (r_col == RW'(N-1));

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && (bus.len != '0)) begin
                    w_state_nxt = LOAD;
                    w_clear     = 1'b1;
                end
            end
            LOAD: begin
                w_adv = 1'b1;
                if (w_last_beat) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                w_adv = 1'b1;
                if (w_drain_end) w_state_nxt = OUT;
            end
            OUT: begin
                if (w_out_xfer && w_out_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_dcnt  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_out_xfer && w_out_last;
            if (w_clear) begin
                r_len  <= bus.len;
                r_cnt  <= '0;
                r_dcnt <= '0;
                r_row  <= '0;
                r_col  <= '0;
            end
            if (w_in_xfer) r_cnt <= r_cnt + LW'(1);
            if (r_state == DRAIN) r_dcnt <= r_dcnt + DCW'(1);
            if (w_out_xfer) begin
                if (w_out_last) begin
                    r_row <= '0;
                    r_col <= '0;
                end else if (r_col == RW'(N-1)) begin
                    r_col <= '0;
                    r_row <= r_row + RW'(1);
                end else begin
                    r_col <= r_col + RW'(1);
                end
            end
        end
    end

    // Lane i is delayed i stages so row i / column i enter the grid aligned with its wavefront.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign w_a_lane[gi] = w_in_xfer ? bus.a_in[gi*DW +: DW] : '0;
        assign w_b_lane[gi] = w_in_xfer ? bus.b_in[gi*DW +: DW] : '0;
        if (gi == 0) begin : g_nodly
            assign w_a_sk[gi] = w_a_lane[gi];
            assign w_b_sk[gi] = w_b_lane[gi];
        end else begin : g_dly
            logic signed [DW-1:0] r_a_dl [gi];
            logic signed [DW-1:0] r_b_dl [gi];
            always_ff @(posedge clk) begin
                if (!rst || w_clear) begin
                    for (int s = 0; s < gi; s++) begin
                        r_a_dl[s] <= '0;
                        r_b_dl[s] <= '0;
                    end
                end else if (w_adv) begin
                    r_a_dl[0] <= w_a_lane[gi];
                    r_b_dl[0] <= w_b_lane[gi];
                    for (int s = 1; s < gi; s++) begin
                        r_a_dl[s] <= r_a_dl[s-1];
                        r_b_dl[s] <= r_b_dl[s-1];
                    end
                end
            end
            assign w_a_sk[gi] = r_a_dl[gi-1];
            assign w_b_sk[gi] = r_b_dl[gi-1];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_pe
            logic signed [DW-1:0]   w_a_i;
            logic signed [DW-1:0]   w_b_i;
            logic signed [DW-1:0]   r_a;
            logic signed [DW-1:0]   r_b;
            logic signed [ACCW-1:0] r_acc;
            logic signed [2*DW-1:0] w_prod;

            if (gj == 0) begin : g_aw
                assign w_a_i = w_a_sk[gi];
            end else begin : g_an
                assign w_a_i = w_pa[gi][gj-1];
            end
            if (gi == 0) begin : g_bn
                assign w_b_i = w_b_sk[gj];
            end else begin : g_bu
                assign w_b_i = w_pb[gi-1][gj];
            end

            assign w_prod = r_a * r_b;

            always_ff @(posedge clk) begin
                if (!rst || w_clear) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_acc <= '0;
                end else if (w_adv) begin
                    r_a   <= w_a_i;
                    r_b   <= w_b_i;
                    r_acc <= r_acc + ACCW'(w_prod);
                end
            end

            assign w_pa[gi][gj]  = r_a;
            assign w_pb[gi][gj]  = r_b;
            assign w_acc[gi][gj] = r_acc;
        end
    end

    assign bus.in_ready  = (r_state == LOAD);
    assign bus.out_valid = (r_state == OUT);
    assign bus.out_last  = w_out_last;
    assign bus.out_data  = (r_state == OUT) ? w_acc[r_row][r_col] : '0;
    assign bus.out_row   = r_row;
    assign bus.out_col   = r_col;
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = r_done;
endmodule

// File: tb/tb_systolic_n.sv
// Bench for systolic_n: a 40-bit and a 32-bit accumulator instance run in lockstep against a plain-sum matrix model.
module tb_systolic_n;
    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int LW   = 8;
    localparam int KMAX = 256;
    localparam int RW   = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    systolic_n_if #(.N(N), .DW(DW), .ACCW(40), .LW(LW)) bus ();
    systolic_n_if #(.N(N), .DW(DW), .ACCW(32), .LW(LW)) bus32 ();

    systolic_n #(.N(N), .DW(DW), .ACCW(40), .LW(LW)) u_dut   (.clk(clk), .rst(rst), .bus(bus));
    systolic_n #(.N(N), .DW(DW), .ACCW(32), .LW(LW)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

    assign bus32.start     = bus.start;
    assign bus32.len       = bus.len;
    assign bus32.a_in      = bus.a_in;
    assign bus32.b_in      = bus.b_in;
    assign bus32.in_valid  = bus.in_valid;
    assign bus32.out_ready = bus.out_ready;

    int checks = 0;
    int errors = 0;

    int     A [N][KMAX];
    int     B [KMAX][N];
    longint got40 [N][N];
    longint got32 [N][N];
    int beats, first_ov, done_cyc, nout, order_err, stab_err, last_err, extra_rdy, lock_err;
    int busy1, busy_done, done_after;

    function automatic longint exp_c(int r, int c, int k, int w);
        longint s = 0;
        for (int kk = 0; kk < k; kk++) s += longint'(A[r][kk]) * longint'(B[kk][c]);
        s = s <<< (64 - w);
        return s >>> (64 - w);
    endfunction

    function automatic int rnd16();
        logic [15:0] v = 16'($urandom);
        return int'($signed(v));
    endfunction

    // Caller is at a falling edge; start is presented in that cycle (cycle 0).
    task automatic run_product(input int k, input int vmode, input int rmode, input bit restart);
        logic [39:0]   p_data;
        logic [RW-1:0] p_row, p_col;
        logic          p_last, p_stall;
        beats = 0; first_ov = -1; done_cyc = -1; nout = 0;
        order_err = 0; stab_err = 0; last_err = 0; extra_rdy = 0; lock_err = 0;
        busy1 = -1; busy_done = -1; p_stall = 1'b0;
        p_data = '0; p_row = '0; p_col = '0; p_last = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                got40[r][c] = 64'h7fff_0000_dead_beef;
                got32[r][c] = 64'h7fff_0000_dead_beef;
            end
        bus.start = 1'b1; bus.len = LW'(k); bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        for (int cyc = 1; cyc < 3000 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            bus.start = restart && (cyc == 2);
            if (restart && cyc == 2) bus.len = LW'(k + 5);
            if (cyc == 1) busy1 = int'(bus.busy);
            if (bus.done) begin
                done_cyc  = cyc;
                busy_done = int'(bus.busy);
            end else begin
                if (bus.out_valid && first_ov < 0) first_ov = cyc;
                if (p_stall && (bus.out_valid !== 1'b1 || bus.out_data !== p_data ||
                    bus.out_row !== p_row || bus.out_col !== p_col || bus.out_last !== p_last))
                    stab_err++;
                if (bus32.out_valid !== bus.out_valid) lock_err++;
                bus.out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 != 0) : 1'($urandom_range(0, 1));
                if (bus.out_valid && bus.out_ready) begin
                    if (int'(bus.out_row) != nout / N || int'(bus.out_col) != nout % N) order_err++;
                    if (bus.out_last !== (nout == N*N - 1)) last_err++;
                    got40[bus.out_row][bus.out_col] = longint'($signed(bus.out_data));
                    got32[bus.out_row][bus.out_col] = longint'($signed(bus32.out_data));
                    nout++;
                end
                p_stall = bus.out_valid && !bus.out_ready;
                p_data = bus.out_data; p_row = bus.out_row; p_col = bus.out_col; p_last = bus.out_last;
                if (bus.in_ready && beats >= k) extra_rdy++;
                bus.in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(cyc & 1) : 1'($urandom_range(0, 1));
                for (int i = 0; i < N; i++) begin
                    bus.a_in[i*DW +: DW] = (beats < k) ? DW'(A[i][beats]) : DW'($urandom);
                    bus.b_in[i*DW +: DW] = (beats < k) ? DW'(B[beats][i]) : DW'($urandom);
                end
                if (bus.in_valid && bus.in_ready) beats++;
            end
        end
        @(negedge clk);
        done_after = int'(bus.done);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    endtask

    task automatic load_identity();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                A[i][k] = (i == k) ? 1 : 0;
                B[k][i] = k * N + i + 1;
            end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0; bus.len = '0; bus.a_in = '0; bus.b_in = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.out_data, bus.out_row, bus.out_col} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h row=%0d col=%0d flags=%b%b%b%b%b want all 0", bus.out_data, bus.out_row,
                     bus.out_col, bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done);
        end
        checks++;
        if ({bus32.in_ready, bus32.out_valid, bus32.busy, bus32.done, bus32.out_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs32 got data=%h want 0", bus32.out_data);
        end
        rst = 1'b1;
    endtask

    task automatic test_identity();
        load_identity();
        run_product(4, 0, 0, 1'b0);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                checks++;
                if (got40[r][c] !== longint'(B[r][c])) begin
                    errors++;
                    $display("FAIL identity C[%0d][%0d] got %0d want %0d", r, c, got40[r][c], B[r][c]);
                end
            end
        checks++;
        if (first_ov != 12) begin errors++; $display("FAIL identity_first_valid got %0d want 12", first_ov); end
        checks++;
        if (done_cyc - first_ov != 16) begin errors++; $display("FAIL identity_done_gap got %0d want 16", done_cyc - first_ov); end
        checks++;
        if (busy1 != 1) begin errors++; $display("FAIL identity_busy_rise got %0d want 1", busy1); end
        checks++;
        if (busy_done != 0) begin errors++; $display("FAIL identity_busy_at_done got %0d want 0", busy_done); end
        checks++;
        if (done_after != 0) begin errors++; $display("FAIL identity_done_width got %0d want 0", done_after); end
        checks++;
        if (order_err != 0 || last_err != 0 || nout != N*N) begin
            errors++;
            $display("FAIL identity_order got order_err=%0d last_err=%0d n=%0d want 0 0 16", order_err, last_err, nout);
        end
    endtask

    task automatic test_extremes();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 255; k++) begin
                A[i][k] = -32768;
                B[k][i] = -32768;
            end
        run_product(255, 0, 0, 1'b0);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                checks++;
                if (got40[r][c] !== exp_c(r, c, 255, 40)) begin
                    errors++;
                    $display("FAIL extremes40 C[%0d][%0d] got %0d want %0d", r, c, got40[r][c], exp_c(r, c, 255, 40));
                end
                checks++;
                if (got32[r][c] !== exp_c(r, c, 255, 32)) begin
                    errors++;
                    $display("FAIL extremes32 C[%0d][%0d] got %0d want %0d", r, c, got32[r][c], exp_c(r, c, 255, 32));
                end
            end
        checks++;
        if (got40[N-1][N-1] !== 64'sd273804165120) begin
            errors++; $display("FAIL extremes40_const got %0d want 273804165120", got40[N-1][N-1]);
        end
        checks++;
        if (got32[0][0] !== -64'sd1073741824) begin
            errors++; $display("FAIL extremes32_const got %0d want -1073741824", got32[0][0]);
        end
        checks++;
        if (lock_err != 0) begin errors++; $display("FAIL extremes_lockstep got %0d want 0", lock_err); end
    endtask

    task automatic test_bubbles_backpressure();
        load_identity();
        run_product(4, 1, 1, 1'b0);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                checks++;
                if (got40[r][c] !== longint'(B[r][c])) begin
                    errors++;
                    $display("FAIL bubbles C[%0d][%0d] got %0d want %0d", r, c, got40[r][c], B[r][c]);
                end
            end
        checks++;
        if (stab_err != 0) begin errors++; $display("FAIL bubbles_stall_stable got %0d want 0", stab_err); end
        checks++;
        if (order_err != 0 || nout != N*N || done_cyc < 0) begin
            errors++;
            $display("FAIL bubbles_order got order_err=%0d n=%0d done=%0d want 0 16 >0", order_err, nout, done_cyc);
        end
    endtask

    task automatic test_protocol();
        int saw_busy;
        saw_busy = 0;
        bus.start = 1'b1; bus.len = '0;
        repeat (3) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy || bus.in_ready) saw_busy++;
        end
        checks++;
        if (saw_busy != 0) begin errors++; $display("FAIL zero_len_busy got %0d want 0", saw_busy); end
        load_identity();
        run_product(4, 0, 0, 1'b1);
        checks++;
        if (beats != 4) begin errors++; $display("FAIL restart_beats got %0d want 4", beats); end
        checks++;
        if (extra_rdy != 0) begin errors++; $display("FAIL extra_ready got %0d want 0", extra_rdy); end
        checks++;
        if (first_ov != 12) begin errors++; $display("FAIL restart_first_valid got %0d want 12", first_ov); end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                checks++;
                if (got40[r][c] !== longint'(B[r][c])) begin
                    errors++;
                    $display("FAIL restart C[%0d][%0d] got %0d want %0d", r, c, got40[r][c], B[r][c]);
                end
            end
    endtask

    task automatic test_reset_abort();
        bus.start = 1'b1; bus.len = LW'(2);
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.a_in[i*DW +: DW] = DW'(rnd16());
            bus.b_in[i*DW +: DW] = DW'(rnd16());
        end
        repeat (4) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL abort_in_drain got busy=%b rdy=%b ov=%b want 1 0 0", bus.busy, bus.in_ready, bus.out_valid);
        end
        rst = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.out_data, bus.out_row, bus.out_col} !== '0) begin
            errors++;
            $display("FAIL abort_outputs got data=%h busy=%b done=%b want 0", bus.out_data, bus.busy, bus.done);
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            A[i][0] = i + 1;
            B[0][i] = 1;
        end
        rst = 1'b1;
        run_product(1, 0, 0, 1'b0);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                checks++;
                if (got40[r][c] !== longint'(r + 1)) begin
                    errors++; $display("FAIL abort_rerun C[%0d][%0d] got %0d want %0d", r, c, got40[r][c], r + 1);
                end
            end
        checks++;
        if (first_ov != 9) begin errors++; $display("FAIL abort_rerun_first_valid got %0d want 9", first_ov); end
    endtask

    task automatic test_random();
        int k;
        for (int it = 0; it < 6; it++) begin
            k = $urandom_range(1, 24);
            for (int i = 0; i < N; i++)
                for (int kk = 0; kk < k; kk++) begin
                    A[i][kk] = rnd16();
                    B[kk][i] = rnd16();
                end
            run_product(k, 2, 2, 1'b0);
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    checks++;
                    if (got40[r][c] !== exp_c(r, c, k, 40) || got32[r][c] !== exp_c(r, c, k, 32)) begin
                        errors++;
                        $display("FAIL random%0d C[%0d][%0d] got %0d/%0d want %0d/%0d", it, r, c, got40[r][c], got32[r][c],
                                 exp_c(r, c, k, 40), exp_c(r, c, k, 32));
                    end
                end
            checks++;
            if (done_cyc < 0 || order_err != 0 || stab_err != 0 || nout != N*N || beats != k) begin
                errors++;
                $display("FAIL random%0d_protocol got done=%0d order=%0d stab=%0d n=%0d beats=%0d want >0 0 0 16 %0d",
                         it, done_cyc, order_err, stab_err, nout, beats, k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_extremes();
        test_bubbles_backpressure();
        test_protocol();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
